// File: rtl/axi_slice_pkg.sv
// Shared types and field widths for the AXI4 register slice.
package axi_slice_pkg;

   typedef enum logic [1:0] {
      BYPASS = 2'd0,
      FWD    = 2'd1,
      FULL   = 2'd2
   } slice_mode_e;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } skid_state_e;

   localparam int LEN_W   = 8;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int LOCK_W  = 1;
   localparam int CACHE_W = 4;
   localparam int PROT_W  = 3;
   localparam int QOS_W   = 4;
   localparam int RESP_W  = 2;

   localparam int CH_AW = 0;
   localparam int CH_W  = 1;
   localparam int CH_B  = 2;
   localparam int CH_AR = 3;
   localparam int CH_R  = 4;

   // Width of the packed AW/AR payload bus.
   function automatic int ax_width(input int addr_w, input int id_w, input int user_w);
      return addr_w + id_w + LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W + PROT_W + QOS_W + user_w;
   endfunction

endpackage

// File: rtl/axi_reg_slice_if.sv
// AXI4 bus bundle. "master" drives AW/W/AR and the B/R ready; "slave" is the mirror.
interface axi_reg_slice_if
   import axi_slice_pkg::*;
#(
   parameter int ADDR_W = 40,
   parameter int DATA_W = 128,
   parameter int ID_W   = 16,
   parameter int USER_W = 16
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0]  awaddr;
   logic [ID_W-1:0]    awid;
   logic [LEN_W-1:0]   awlen;
   logic [SIZE_W-1:0]  awsize;
   logic [BURST_W-1:0] awburst;
   logic [LOCK_W-1:0]  awlock;
   logic [CACHE_W-1:0] awcache;
   logic [PROT_W-1:0]  awprot;
   logic [QOS_W-1:0]   awqos;
   logic [USER_W-1:0]  awuser;
   logic               awvalid;
   logic               awready;

   logic [DATA_W-1:0]  wdata;
   logic [STRB_W-1:0]  wstrb;
   logic [ID_W-1:0]    wid;
   logic               wlast;
   logic               wvalid;
   logic               wready;

   logic [RESP_W-1:0]  bresp;
   logic [ID_W-1:0]    bid;
   logic               bvalid;
   logic               bready;

   logic [ADDR_W-1:0]  araddr;
   logic [ID_W-1:0]    arid;
   logic [LEN_W-1:0]   arlen;
   logic [SIZE_W-1:0]  arsize;
   logic [BURST_W-1:0] arburst;
   logic [LOCK_W-1:0]  arlock;
   logic [CACHE_W-1:0] arcache;
   logic [PROT_W-1:0]  arprot;
   logic [QOS_W-1:0]   arqos;
   logic [USER_W-1:0]  aruser;
   logic               arvalid;
   logic               arready;

   logic [DATA_W-1:0]  rdata;
   logic [RESP_W-1:0]  rresp;
   logic [ID_W-1:0]    rid;
   logic               rlast;
   logic               rvalid;
   logic               rready;

   modport master (
      output awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
      input  awready,
      output wdata, wstrb, wid, wlast, wvalid,
      input  wready,
      input  bresp, bid, bvalid,
      output bready,
      output araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
      input  arready,
      input  rdata, rresp, rid, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
      output awready,
      input  wdata, wstrb, wid, wlast, wvalid,
      output wready,
      output bresp, bid, bvalid,
      input  bready,
      input  araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
      output arready,
      output rdata, rresp, rid, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_skid_slice.sv
// Generic single-channel valid/ready slice: BYPASS, FWD (forward-registered) or FULL (2-entry skid).
// Optional stall counter when AXI_SLICE_STALL_CNT_EN is defined.
//
// FULL-mode states:
//   state   | meaning
//   S_EMPTY | no beat held, src_ready = 1 (after reset release)
//   S_ONE   | main entry holds a beat, src_ready = 1
//   S_TWO   | main and skid entries full, src_ready = 0
module axi_skid_slice
   import axi_slice_pkg::*;
#(
   parameter int          W     = 8,
   parameter slice_mode_e MODE  = FULL,
   parameter int          CNT_W = 32
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         src_valid,
   output logic         src_ready,
   input  logic [W-1:0] src_data,
   output logic         dst_valid,
   input  logic         dst_ready,
   output logic [W-1:0] dst_data
`ifdef AXI_SLICE_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   generate
      if (MODE == BYPASS) begin : g_bypass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign dst_valid = src_valid;
         assign dst_data  = src_data;
         assign src_ready = dst_ready;
      end else if (MODE == FWD) begin : g_fwd
         logic         vld_q;
         logic [W-1:0] pay_q;

         assign src_ready = !vld_q || dst_ready;
         assign dst_valid = vld_q;
         assign dst_data  = pay_q;

         // Single holding register; refills in the same cycle it drains.
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= 1'b0;
               pay_q <= '0;
            end else if (src_valid && src_ready) begin
               vld_q <= 1'b1;
               pay_q <= src_data;
            end else if (vld_q && dst_ready) begin
               vld_q <= 1'b0;
            end
         end
      end else begin : g_full
         skid_state_e  st_q;
         logic         vld_q;
         logic         rdy_q;
         logic [W-1:0] main_q;
         logic [W-1:0] skid_q;
         logic         acc;

         assign acc       = src_valid && rdy_q;
         assign src_ready = rdy_q;
         assign dst_valid = vld_q;
         assign dst_data  = main_q;

         // Skid FSM: every output comes straight from a flop.
         always_ff @(posedge clk) begin
            if (rst) begin
               st_q   <= S_EMPTY;
               vld_q  <= 1'b0;
               rdy_q  <= 1'b0;
               main_q <= '0;
               skid_q <= '0;
            end else begin
               case (st_q)
                  S_EMPTY: begin
                     rdy_q <= 1'b1;
                     if (acc) begin
                        main_q <= src_data;
                        vld_q  <= 1'b1;
                        st_q   <= S_ONE;
                     end
                  end
                  S_ONE: begin
                     if (acc && !dst_ready) begin
                        skid_q <= src_data;
                        rdy_q  <= 1'b0;
                        st_q   <= S_TWO;
                     end else if (acc) begin
                        main_q <= src_data;
                     end else if (dst_ready) begin
                        vld_q <= 1'b0;
                        st_q  <= S_EMPTY;
                     end
                  end
                  S_TWO: begin
                     if (dst_ready) begin
                        main_q <= skid_q;
                        rdy_q  <= 1'b1;
                        st_q   <= S_ONE;
                     end
                  end
                  default: begin
                     st_q  <= S_EMPTY;
                     vld_q <= 1'b0;
                     rdy_q <= 1'b0;
                  end
               endcase
            end
         end
      end
   endgenerate

`ifdef AXI_SLICE_STALL_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of cycles where the downstream holds off a valid beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (dst_valid && !dst_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign stall_cnt = cnt_q;
`endif

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: five independent channel slices between upstream s_axi and downstream m_axi.
// Optional per-channel stall counters when AXI_SLICE_STALL_CNT_EN is defined.
module axi_reg_slice
   import axi_slice_pkg::*;
#(
   parameter int          ADDR_W  = 40,
   parameter int          DATA_W  = 128,
   parameter int          ID_W    = 16,
   parameter int          USER_W  = 16,
   parameter slice_mode_e AW_MODE = FULL,
   parameter slice_mode_e W_MODE  = FULL,
   parameter slice_mode_e B_MODE  = FWD,
   parameter slice_mode_e AR_MODE = FULL,
   parameter slice_mode_e R_MODE  = FULL,
   parameter int          CNT_W   = 32
)(
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_areset,
   axi_reg_slice_if.slave        s_axi,
   axi_reg_slice_if.master       m_axi
`ifdef AXI_SLICE_STALL_CNT_EN
   ,
   output logic [5*CNT_W-1:0]    stall_cnt
`endif
);

   localparam int STRB_W = DATA_W / 8;
   localparam int AX_W   = ax_width(ADDR_W, ID_W, USER_W);
   localparam int W_W    = DATA_W + STRB_W + ID_W + 1;
   localparam int B_W    = RESP_W + ID_W;
   localparam int R_W    = DATA_W + RESP_W + ID_W + 1;

   logic [AX_W-1:0] aw_src, aw_dst, ar_src, ar_dst;
   logic [W_W-1:0]  w_src, w_dst;
   logic [B_W-1:0]  b_src, b_dst;
   logic [R_W-1:0]  r_src, r_dst;

   assign aw_src = {s_axi.awaddr, s_axi.awid, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                    s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awuser};
   assign {m_axi.awaddr, m_axi.awid, m_axi.awlen, m_axi.awsize, m_axi.awburst,
           m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos, m_axi.awuser} = aw_dst;

   assign w_src = {s_axi.wdata, s_axi.wstrb, s_axi.wid, s_axi.wlast};
   assign {m_axi.wdata, m_axi.wstrb, m_axi.wid, m_axi.wlast} = w_dst;

   assign b_src = {m_axi.bresp, m_axi.bid};
   assign {s_axi.bresp, s_axi.bid} = b_dst;

   assign ar_src = {s_axi.araddr, s_axi.arid, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                    s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.aruser};
   assign {m_axi.araddr, m_axi.arid, m_axi.arlen, m_axi.arsize, m_axi.arburst,
           m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos, m_axi.aruser} = ar_dst;

   assign r_src = {m_axi.rdata, m_axi.rresp, m_axi.rid, m_axi.rlast};
   assign {s_axi.rdata, s_axi.rresp, s_axi.rid, s_axi.rlast} = r_dst;

`ifdef AXI_SLICE_STALL_CNT_EN
   `define AXI_SLICE_CNT_PARAM , .CNT_W(CNT_W)
`else
   `define AXI_SLICE_CNT_PARAM
`endif

   axi_skid_slice #(.W(AX_W), .MODE(AW_MODE) `AXI_SLICE_CNT_PARAM) u_aw (
      .clk(s_axi_aclk), .rst(s_axi_areset),
      .src_valid(s_axi.awvalid), .src_ready(s_axi.awready), .src_data(aw_src),
      .dst_valid(m_axi.awvalid), .dst_ready(m_axi.awready), .dst_data(aw_dst)
`ifdef AXI_SLICE_STALL_CNT_EN
      , .stall_cnt(stall_cnt[CH_AW*CNT_W +: CNT_W])
`endif
   );

   axi_skid_slice #(.W(W_W), .MODE(W_MODE) `AXI_SLICE_CNT_PARAM) u_w (
      .clk(s_axi_aclk), .rst(s_axi_areset),
      .src_valid(s_axi.wvalid), .src_ready(s_axi.wready), .src_data(w_src),
      .dst_valid(m_axi.wvalid), .dst_ready(m_axi.wready), .dst_data(w_dst)
`ifdef AXI_SLICE_STALL_CNT_EN
      , .stall_cnt(stall_cnt[CH_W*CNT_W +: CNT_W])
`endif
   );

   axi_skid_slice #(.W(B_W), .MODE(B_MODE) `AXI_SLICE_CNT_PARAM) u_b (
      .clk(s_axi_aclk), .rst(s_axi_areset),
      .src_valid(m_axi.bvalid), .src_ready(m_axi.bready), .src_data(b_src),
      .dst_valid(s_axi.bvalid), .dst_ready(s_axi.bready), .dst_data(b_dst)
`ifdef AXI_SLICE_STALL_CNT_EN
      , .stall_cnt(stall_cnt[CH_B*CNT_W +: CNT_W])
`endif
   );

   axi_skid_slice #(.W(AX_W), .MODE(AR_MODE) `AXI_SLICE_CNT_PARAM) u_ar (
      .clk(s_axi_aclk), .rst(s_axi_areset),
      .src_valid(s_axi.arvalid), .src_ready(s_axi.arready), .src_data(ar_src),
      .dst_valid(m_axi.arvalid), .dst_ready(m_axi.arready), .dst_data(ar_dst)
`ifdef AXI_SLICE_STALL_CNT_EN
      , .stall_cnt(stall_cnt[CH_AR*CNT_W +: CNT_W])
`endif
   );

   axi_skid_slice #(.W(R_W), .MODE(R_MODE) `AXI_SLICE_CNT_PARAM) u_r (
      .clk(s_axi_aclk), .rst(s_axi_areset),
      .src_valid(m_axi.rvalid), .src_ready(m_axi.rready), .src_data(r_src),
      .dst_valid(s_axi.rvalid), .dst_ready(s_axi.rready), .dst_data(r_dst)
`ifdef AXI_SLICE_STALL_CNT_EN
      , .stall_cnt(stall_cnt[CH_R*CNT_W +: CNT_W])
`endif
   );

`undef AXI_SLICE_CNT_PARAM

endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed bench for axi_reg_slice: AW/W/AR FULL, B BYPASS, R FWD.
// Stall-counter scenario is compiled in when AXI_SLICE_STALL_CNT_EN is defined.
module tb_axi_reg_slice;
   import axi_slice_pkg::*;

   localparam int ADDR_W = 40;
   localparam int DATA_W = 128;
   localparam int ID_W   = 16;
   localparam int USER_W = 16;
   localparam int CNT_W  = 32;

   logic s_axi_aclk;
   logic s_axi_areset;
   int   n_checks;
   int   n_pass;

   axi_reg_slice_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)) s_if ();
   axi_reg_slice_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)) m_if ();

`ifdef AXI_SLICE_STALL_CNT_EN
   logic [5*CNT_W-1:0] stall_cnt;
`endif

   axi_reg_slice #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W),
      .AW_MODE(FULL), .W_MODE(FULL), .B_MODE(BYPASS), .AR_MODE(FULL), .R_MODE(FWD),
      .CNT_W(CNT_W)
   ) dut (
      .s_axi_aclk(s_axi_aclk),
      .s_axi_areset(s_axi_areset),
      .s_axi(s_if),
      .m_axi(m_if)
`ifdef AXI_SLICE_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   initial s_axi_aclk = 1'b0;
   always #5 s_axi_aclk = ~s_axi_aclk;

   task automatic drive_idle();
      s_if.awaddr = '0; s_if.awid = '0; s_if.awlen = '0; s_if.awsize = '0; s_if.awburst = '0;
      s_if.awlock = '0; s_if.awcache = '0; s_if.awprot = '0; s_if.awqos = '0; s_if.awuser = '0;
      s_if.awvalid = 1'b0;
      s_if.wdata = '0; s_if.wstrb = '0; s_if.wid = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
      s_if.bready = 1'b1;
      s_if.araddr = '0; s_if.arid = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arburst = '0;
      s_if.arlock = '0; s_if.arcache = '0; s_if.arprot = '0; s_if.arqos = '0; s_if.aruser = '0;
      s_if.arvalid = 1'b0;
      s_if.rready = 1'b1;
      m_if.awready = 1'b1;
      m_if.wready = 1'b1;
      m_if.bresp = '0; m_if.bid = '0; m_if.bvalid = 1'b0;
      m_if.arready = 1'b1;
      m_if.rdata = '0; m_if.rresp = '0; m_if.rid = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;
   endtask

   task automatic next_cyc();
      @(posedge s_axi_aclk);
      #1;
   endtask

   task automatic test_reset();
      s_axi_areset = 1'b1;
      drive_idle();
      repeat (3) next_cyc();
      #1;
      n_checks++; if (m_if.awvalid !== 1'b0) $display("FAIL rst_awvalid: got %0b want 0", m_if.awvalid); else n_pass++;
      n_checks++; if (m_if.wvalid !== 1'b0) $display("FAIL rst_wvalid: got %0b want 0", m_if.wvalid); else n_pass++;
      n_checks++; if (m_if.arvalid !== 1'b0) $display("FAIL rst_arvalid: got %0b want 0", m_if.arvalid); else n_pass++;
      n_checks++; if (s_if.rvalid !== 1'b0) $display("FAIL rst_rvalid: got %0b want 0", s_if.rvalid); else n_pass++;
      n_checks++; if (s_if.awready !== 1'b0) $display("FAIL rst_awready: got %0b want 0", s_if.awready); else n_pass++;
      n_checks++; if (s_if.arready !== 1'b0) $display("FAIL rst_arready: got %0b want 0", s_if.arready); else n_pass++;
      n_checks++; if (m_if.awaddr !== '0) $display("FAIL rst_awaddr: got %h want 0", m_if.awaddr); else n_pass++;
      s_axi_areset = 1'b0;
      next_cyc();
      #1;
      n_checks++; if (s_if.awready !== 1'b1) $display("FAIL rel_awready: got %0b want 1", s_if.awready); else n_pass++;
      n_checks++; if (s_if.wready !== 1'b1) $display("FAIL rel_wready: got %0b want 1", s_if.wready); else n_pass++;
      n_checks++; if (s_if.arready !== 1'b1) $display("FAIL rel_arready: got %0b want 1", s_if.arready); else n_pass++;
      n_checks++; if (m_if.rready !== 1'b1) $display("FAIL rel_m_rready: got %0b want 1", m_if.rready); else n_pass++;
   endtask

   task automatic test_back_to_back();
      m_if.awready = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         next_cyc();
         s_if.awvalid = (k < 8);
         s_if.awaddr  = ADDR_W'(k);
         s_if.awid    = ID_W'(k + 16'h100);
         #1;
         if (k < 8) begin
            n_checks++; if (s_if.awready !== 1'b1) $display("FAIL b2b_awready c%0d: got %0b want 1", k, s_if.awready); else n_pass++;
         end
         if (k >= 1 && k <= 8) begin
            n_checks++; if (m_if.awvalid !== 1'b1) $display("FAIL b2b_awvalid c%0d: got %0b want 1", k, m_if.awvalid); else n_pass++;
            n_checks++; if (m_if.awaddr !== ADDR_W'(k - 1)) $display("FAIL b2b_awaddr c%0d: got %h want %h", k, m_if.awaddr, k - 1); else n_pass++;
            n_checks++; if (m_if.awid !== ID_W'(k - 1 + 16'h100)) $display("FAIL b2b_awid c%0d: got %h want %h", k, m_if.awid, k - 1 + 16'h100); else n_pass++;
         end
         if (k == 0 || k == 9) begin
            n_checks++; if (m_if.awvalid !== 1'b0) $display("FAIL b2b_idle c%0d: got %0b want 0", k, m_if.awvalid); else n_pass++;
         end
      end
      drive_idle();
   endtask

   task automatic test_w_stall();
      int sent;
      int got;
      int k;
      sent = 0; got = 0; k = 0;
      while (got < 16 && k < 60) begin
         next_cyc();
         s_if.wvalid = (sent < 16);
         s_if.wdata  = DATA_W'(sent);
         s_if.wid    = ID_W'(sent);
         s_if.wstrb  = '1;
         s_if.wlast  = (sent == 15);
         m_if.wready = !(k >= 4 && k <= 7);
         #1;
         if (k <= 10) begin
            n_checks++;
            if (s_if.wready !== !(k >= 5 && k <= 8))
               $display("FAIL w_ready c%0d: got %0b want %0b", k, s_if.wready, !(k >= 5 && k <= 8));
            else n_pass++;
         end
         if (m_if.wvalid && m_if.wready) begin
            n_checks++; if (m_if.wdata !== DATA_W'(got)) $display("FAIL w_data beat%0d: got %h want %h", got, m_if.wdata, got); else n_pass++;
            n_checks++; if (m_if.wlast !== (got == 15)) $display("FAIL w_last beat%0d: got %0b want %0b", got, m_if.wlast, got == 15); else n_pass++;
            got++;
         end
         if (s_if.wvalid && s_if.wready) sent++;
         k++;
      end
      n_checks++; if (got !== 16) $display("FAIL w_count: got %0d beats want 16", got); else n_pass++;
      s_if.wvalid = 1'b0;
      m_if.wready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         next_cyc();
         #1;
         n_checks++; if (m_if.wvalid !== 1'b0) $display("FAIL w_extra c%0d: got %0b want 0", c, m_if.wvalid); else n_pass++;
      end
      drive_idle();
   endtask

   task automatic test_fwd_random();
      int sent;
      int got;
      int cyc;
      logic prev_stall;
      logic [DATA_W-1:0] prev_data;
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
      while (got < 200 && cyc < 2000) begin
         next_cyc();
         m_if.rvalid = (sent < 200) && ($urandom_range(0, 3) != 0);
         m_if.rdata  = DATA_W'(sent);
         m_if.rid    = ID_W'(sent);
         m_if.rlast  = ((sent % 4) == 3);
         m_if.rresp  = RESP_W'(sent);
         s_if.rready = 1'($urandom_range(0, 1));
         #1;
         if (prev_stall) begin
            n_checks++; if (s_if.rvalid !== 1'b1) $display("FAIL r_hold_valid c%0d: got %0b want 1", cyc, s_if.rvalid); else n_pass++;
            n_checks++; if (s_if.rdata !== prev_data) $display("FAIL r_hold_data c%0d: got %h want %h", cyc, s_if.rdata, prev_data); else n_pass++;
         end
         if (s_if.rvalid && s_if.rready) begin
            n_checks++; if (s_if.rdata !== DATA_W'(got)) $display("FAIL r_data beat%0d: got %h want %h", got, s_if.rdata, got); else n_pass++;
            n_checks++; if (s_if.rid !== ID_W'(got)) $display("FAIL r_id beat%0d: got %h want %h", got, s_if.rid, got); else n_pass++;
            n_checks++; if (s_if.rlast !== ((got % 4) == 3)) $display("FAIL r_last beat%0d: got %0b want %0b", got, s_if.rlast, (got % 4) == 3); else n_pass++;
            got++;
         end
         if (m_if.rvalid && m_if.rready) sent++;
         prev_stall = s_if.rvalid && !s_if.rready;
         prev_data  = s_if.rdata;
         cyc++;
      end
      n_checks++; if (got !== 200) $display("FAIL r_count: got %0d beats want 200", got); else n_pass++;
      drive_idle();
      next_cyc();
   endtask

   task automatic test_b_bypass();
      next_cyc();
      m_if.bvalid = 1'b1;
      m_if.bid    = 16'h005A;
      m_if.bresp  = 2'b10;
      s_if.bready = 1'b0;
      #1;
      n_checks++; if (s_if.bvalid !== 1'b1) $display("FAIL b_valid: got %0b want 1", s_if.bvalid); else n_pass++;
      n_checks++; if (s_if.bid !== 16'h005A) $display("FAIL b_id: got %h want 005a", s_if.bid); else n_pass++;
      n_checks++; if (s_if.bresp !== 2'b10) $display("FAIL b_resp: got %b want 10", s_if.bresp); else n_pass++;
      n_checks++; if (m_if.bready !== 1'b0) $display("FAIL b_ready_lo: got %0b want 0", m_if.bready); else n_pass++;
      s_if.bready = 1'b1;
      #1;
      n_checks++; if (m_if.bready !== 1'b1) $display("FAIL b_ready_hi: got %0b want 1", m_if.bready); else n_pass++;
      m_if.bvalid = 1'b0;
      #1;
      n_checks++; if (s_if.bvalid !== 1'b0) $display("FAIL b_valid_off: got %0b want 0", s_if.bvalid); else n_pass++;
      drive_idle();
   endtask

   task automatic test_ar_reset();
      m_if.arready = 1'b0;
      next_cyc();
      s_if.arvalid = 1'b1;
      s_if.araddr  = 40'h100;
      #1;
      n_checks++; if (s_if.arready !== 1'b1) $display("FAIL ar_rdy_c0: got %0b want 1", s_if.arready); else n_pass++;
      next_cyc();
      s_if.araddr = 40'h200;
      #1;
      n_checks++; if (m_if.arvalid !== 1'b1) $display("FAIL ar_vld_c1: got %0b want 1", m_if.arvalid); else n_pass++;
      n_checks++; if (m_if.araddr !== 40'h100) $display("FAIL ar_addr_c1: got %h want 100", m_if.araddr); else n_pass++;
      next_cyc();
      s_if.arvalid = 1'b0;
      s_axi_areset = 1'b1;
      #1;
      n_checks++; if (s_if.arready !== 1'b0) $display("FAIL ar_full_c2: got %0b want 0", s_if.arready); else n_pass++;
      next_cyc();
      s_axi_areset = 1'b0;
      #1;
      n_checks++; if (m_if.arvalid !== 1'b0) $display("FAIL ar_vld_after_rst: got %0b want 0", m_if.arvalid); else n_pass++;
      n_checks++; if (s_if.arready !== 1'b0) $display("FAIL ar_rdy_after_rst: got %0b want 0", s_if.arready); else n_pass++;
      n_checks++; if (m_if.araddr !== '0) $display("FAIL ar_addr_after_rst: got %h want 0", m_if.araddr); else n_pass++;
      next_cyc();
      m_if.arready = 1'b1;
      #1;
      n_checks++; if (s_if.arready !== 1'b1) $display("FAIL ar_rdy_release: got %0b want 1", s_if.arready); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (m_if.arvalid !== 1'b0) $display("FAIL ar_stale c%0d: got %0b want 0", c, m_if.arvalid); else n_pass++;
         next_cyc();
         #1;
      end
      drive_idle();
   endtask

`ifdef AXI_SLICE_STALL_CNT_EN
   task automatic test_stall_cnt();
      next_cyc();
      s_axi_areset = 1'b1;
      next_cyc();
      s_axi_areset = 1'b0;
      #1;
      n_checks++; if (stall_cnt !== '0) $display("FAIL cnt_clear: got %h want 0", stall_cnt); else n_pass++;
      for (int c = 0; c <= 11; c++) begin
         next_cyc();
         if (c == 0) begin
            s_if.awvalid = 1'b1;
            s_if.awaddr  = 40'h55;
            m_if.awready = 1'b0;
         end
         #1;
         if (c >= 1 && c <= 10) begin
            n_checks++; if (m_if.awvalid !== 1'b1) $display("FAIL cnt_awvalid c%0d: got %0b want 1", c, m_if.awvalid); else n_pass++;
         end
         if (c == 11) begin
            n_checks++; if (stall_cnt[CH_AW*CNT_W +: CNT_W] !== 32'd10) $display("FAIL cnt_aw: got %0d want 10", stall_cnt[CH_AW*CNT_W +: CNT_W]); else n_pass++;
            n_checks++; if (stall_cnt[CH_W*CNT_W +: CNT_W] !== 32'd0) $display("FAIL cnt_w: got %0d want 0", stall_cnt[CH_W*CNT_W +: CNT_W]); else n_pass++;
            n_checks++; if (stall_cnt[CH_B*CNT_W +: CNT_W] !== 32'd0) $display("FAIL cnt_b: got %0d want 0", stall_cnt[CH_B*CNT_W +: CNT_W]); else n_pass++;
            n_checks++; if (stall_cnt[CH_AR*CNT_W +: CNT_W] !== 32'd0) $display("FAIL cnt_ar: got %0d want 0", stall_cnt[CH_AR*CNT_W +: CNT_W]); else n_pass++;
            n_checks++; if (stall_cnt[CH_R*CNT_W +: CNT_W] !== 32'd0) $display("FAIL cnt_r: got %0d want 0", stall_cnt[CH_R*CNT_W +: CNT_W]); else n_pass++;
         end
      end
      drive_idle();
      repeat (3) next_cyc();
   endtask
`endif

   initial begin
      n_checks = 0;
      n_pass   = 0;
      s_axi_areset = 1'b1;
      drive_idle();
      test_reset();
      test_back_to_back();
      test_w_stall();
      test_fwd_random();
      test_b_bypass();
      test_ar_reset();
`ifdef AXI_SLICE_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
